// File: rtl/spi_pkg.sv
// Shared types for the SPI slave register sequencer: FSM states, command-byte layout and status byte.
// No logic of its own; latency and flow control live in the modules that import it.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_FETCH,
        RD,
        OVF
    } state_e;

    localparam int         RW_BIT   = 7;
    localparam logic [7:0] OVF_FILL = 8'hFF;

    // Byte presented on MISO while the master clocks in the command byte.
    typedef struct packed {
        logic [6:0] rsvd;
        logic       ovf;
    } status_t;

    function automatic logic [7:0] status_byte(input logic ovf);
        status_t s;
        s.rsvd = '0;
        s.ovf  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/spi_addr_gen.sv
// Register pointer (load / increment with natural wrap) plus per-frame burst byte counter and limit flags.
// Updates on the SCLK edge where load_i/step_i is high; the byte counter is cleared asynchronously by clr_i.
module spi_addr_gen #(
    parameter int ADDR_W    = 7,
    parameter int MAX_BURST = 16,
    parameter int AUTO_INC  = 1
) (
    input  logic              SCLK,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] addr_nxt_o,
    output logic              at_wr_limit_o,
    output logic              at_rd_limit_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign addr_nxt_o = (AUTO_INC != 0) ? addr_q + ADDR_W'(1) : addr_q;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = load_addr_i;
            cnt_d  = '0;
        end else if (step_i) begin
            addr_d = addr_nxt_o;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // The pointer survives a deselect; only the per-frame count is cleared by it.
    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    always_ff @(posedge SCLK or posedge rst or posedge clr_i) begin
        if (rst || clr_i) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    assign addr_o        = addr_q;
    assign at_wr_limit_o = (cnt_q == CNT_W'(MAX_BURST));
    assign at_rd_limit_o = (cnt_q >= CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave command sequencer: decodes {rw, addr}, issues burst writes / prefetched reads, drives tx_byte.
// Write strobe 1 edge after rx_valid, read data in tx_byte 2 edges after; SS high aborts the frame asynchronously.
module spi_slave_reg_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int MAX_BURST = 16,
    parameter int AUTO_INC  = 1
) (
    input  logic              SCLK,
    input  logic              rst,
    input  logic              SS,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err_ovf
);

    state_e            state_q, state_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              err_ovf_q, err_ovf_d;

    logic              ag_load, ag_step;
    logic [ADDR_W-1:0] ag_addr, ag_addr_nxt;
    logic              at_wr_limit, at_rd_limit;

    spi_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .AUTO_INC  (AUTO_INC)
    ) u_addr_gen (
        .SCLK          (SCLK),
        .rst           (rst),
        .clr_i         (SS),
        .load_i        (ag_load),
        .step_i        (ag_step),
        .load_addr_i   (rx_byte[ADDR_W-1:0]),
        .addr_o        (ag_addr),
        .addr_nxt_o    (ag_addr_nxt),
        .at_wr_limit_o (at_wr_limit),
        .at_rd_limit_o (at_rd_limit)
    );

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        err_ovf_d   = err_ovf_q;
        ag_load     = 1'b0;
        ag_step     = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d   = CMD;
                tx_byte_d = status_byte(err_ovf_q);
            end
            CMD: begin
                if (rx_valid) begin
                    ag_load    = 1'b1;
                    reg_addr_d = rx_byte[ADDR_W-1:0];
                    err_ovf_d  = 1'b0;
                    if (rx_byte[RW_BIT]) begin
                        rd_en_d = 1'b1;
                        state_d = RD_FETCH;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (rx_valid) begin
                    if (at_wr_limit) begin
                        err_ovf_d = 1'b1;
                        tx_byte_d = OVF_FILL;
                        state_d   = OVF;
                    end else begin
                        wr_en_d     = 1'b1;
                        reg_wdata_d = rx_byte;
                        reg_addr_d  = ag_addr;
                        ag_step     = 1'b1;
                    end
                end
            end
            RD_FETCH: begin
                tx_byte_d = reg_rdata;
                state_d   = RD;
            end
            RD: begin
                // The byte just exchanged was the prefetched one; fetch the next register.
                if (rx_valid) begin
                    if (at_rd_limit) begin
                        err_ovf_d = 1'b1;
                        tx_byte_d = OVF_FILL;
                        state_d   = OVF;
                    end else begin
                        ag_step    = 1'b1;
                        reg_addr_d = ag_addr_nxt;
                        rd_en_d    = 1'b1;
                        state_d    = RD_FETCH;
                    end
                end
            end
            OVF: begin
                tx_byte_d = OVF_FILL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame-scoped state: deselect clears it without waiting for SCLK.
    always_ff @(posedge SCLK or posedge rst or posedge SS) begin
        if (rst || SS) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
        end
    end

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            tx_byte_q   <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            err_ovf_q   <= 1'b0;
        end else begin
            tx_byte_q   <= tx_byte_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign err_ovf   = err_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule
